alu_issue: RTL
==============

# alu_issue

Issue stage directly upstream of the 32-bit execute ALU. It accepts operand/opcode packets over a valid/ready handshake and buffers them in a small FIFO. It decodes the 2-bit main-control ALU code plus the R-type funct field into the ALU's 3-bit ALUOp, drives the ALU operands from the FIFO head, and captures the ALU's combinational result into a registered, back-pressurable result port.

## Interface
- DEPTH, 4: FIFO entries, power of two, 2..16.
- TAGW, 5: width of the destination tag carried alongside each packet.

- clk  in  1  rising-edge clock, sole clock domain.
- rst  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous clear of FIFO and result register.
- in_valid  in  1  upstream packet valid.
- in_ready  out  1  FIFO can accept; equals (count != DEPTH), combinational from count.
- in_aluop  in  2  main-control code: 00 load/store, 01 branch, 10 R-type, 11 reserved.
- in_funct  in  6  instruction funct field; used only when in_aluop = 10.
- in_a, in_b  in  32  operands.
- in_tag  in  TAGW  destination tag.
- alu_a, alu_b  out  32  to ALU A/B; the FIFO head entry, or 0 when the FIFO is empty.
- alu_op  out  3  to ALU ALUOp; decoded from the FIFO head, or 000 when the FIFO is empty.
- alu_q  in  32  ALU result Q, combinational from alu_a/alu_b/alu_op.
- res_valid  out  1  result register holds data.
- res_ready  in  1  downstream accepts result.
- res_data  out  32  registered ALU result.
- res_tag  out  TAGW  tag of res_data.
- res_err  out  1  result came from an illegal opcode/funct.

## Operation
- Push: in_valid & in_ready at a clock edge writes {aluop, funct, a, b, tag} at the write pointer. Pointers wrap modulo DEPTH.
- No push when full, even if a pop occurs in the same cycle. in_ready does not look at the pop.
- Decode (combinational on the FIFO head):
  - aluop 00 → 010 (add).
  - aluop 01 → 011 (sub).
  - aluop 10 with funct 100000 → 010, 100010 → 011, 100100 → 000, 100101 → 001, 101010 → 100 (slt).
  - Any other funct, or aluop 11 → alu_op 111, err = 1. The ALU returns 0 for this code; res_data = 0.
- Pop/capture: fires when the FIFO is non-empty and (!res_valid | res_ready). On capture:
  - res_data ← alu_q, res_tag ← head tag, res_err ← decoded err, res_valid ← 1.
  - The read pointer advances.
- Result drain: if res_valid & res_ready and nothing is captured, res_valid ← 0.
- Simultaneous push and pop on a non-full, non-empty FIFO: count unchanged, both pointers advance.
- Push into an empty FIFO: the entry reaches the head next cycle. There is no same-cycle bypass.
- flush (synchronous, higher priority than push/pop):
  - Pointers and count ← 0; res_valid ← 0.
  - Handshakes in the flush cycle are discarded.
- count width is clog2(DEPTH)+1. count never exceeds DEPTH and never underflows.

## Timing
- Reset (async assert, held while rst = 1):
  - Pointers = 0, count = 0, res_valid = 0, res_data = 0, res_tag = 0, res_err = 0.
  - Hence in_ready = 1, alu_a = alu_b = 0, alu_op = 000.
- Latency: packet accepted at edge N → at the ALU inputs after N → res_valid at edge N+1 (if the result path is free). Minimum input-to-result latency is 2 edges.
- Throughput: one result per cycle with res_ready held high.
- Back-pressure: while res_valid & !res_ready, res_data, res_tag and res_err hold stable. The FIFO fills, and in_ready drops when count = DEPTH.
- Reset asserted mid-stream: all in-flight packets are lost. No result is emitted after deassert until new input arrives.
- Flush and reset both leave in_ready = 1 on the following cycle.

## Test plan
- Reset, then push {aluop 10, funct 100000, a 5, b 7, tag 3}, res_ready = 1 → res_valid high exactly 2 edges after accept, res_data = 12, res_tag = 3, res_err = 0.
- Push the funct sequence 100010 (a 3, b 5), 100100, 100101, 101010 (a 3, b 5) back-to-back → res_data 0xFFFFFFFE, A&B, A|B, 1 in order, one per cycle.
- Hold res_ready = 0, push DEPTH+2 packets → in_ready = 0 after DEPTH+1 accepts (DEPTH in FIFO plus 1 in the result register); res_data stable; release res_ready → all results drain in order, none lost or duplicated.
- aluop 11, and aluop 10 with funct 000000 → alu_op = 111, res_data = 0, res_err = 1; aluop 00 with a 0xFFFFFFFF, b 1 → res_data = 0.
- With 3 entries queued and res_valid high, assert flush for one cycle while in_valid = 1 → next cycle res_valid = 0, in_ready = 1, and no result ever appears for the flushed packets or the flush-cycle input.
- Assert rst asynchronously mid-stream (between clock edges) → res_valid and count drop immediately, without a clock edge.

Source files
------------

// File: rtl/alu_issue_if.sv
// alu_issue_if: packet-in and result-out handshake bundle for alu_issue.
//   in_*  : upstream packet channel (valid/ready, aluop, funct, operands, tag)
//   res_* : registered result channel (valid/ready, data, tag, error flag)
// slave modport is the issue stage; master modport is its environment.
interface alu_issue_if #(
    parameter int TAGW = 5
) ();
    logic            in_valid;
    logic            in_ready;
    logic [1:0]      in_aluop;
    logic [5:0]      in_funct;
    logic [31:0]     in_a;
    logic [31:0]     in_b;
    logic [TAGW-1:0] in_tag;

    logic            res_valid;
    logic            res_ready;
    logic [31:0]     res_data;
    logic [TAGW-1:0] res_tag;
    logic            res_err;

    modport slave (
        input  in_valid, in_aluop, in_funct, in_a, in_b, in_tag, res_ready,
        output in_ready, res_valid, res_data, res_tag, res_err
    );

    modport master (
        output in_valid, in_aluop, in_funct, in_a, in_b, in_tag, res_ready,
        input  in_ready, res_valid, res_data, res_tag, res_err
    );
endinterface

// File: rtl/alu_issue.sv
// alu_issue: issue stage in front of a 32-bit combinational ALU.
// Buffers operand/opcode packets in a DEPTH-entry FIFO, decodes the head's
// main-control code and funct field into the ALU's 3-bit ALUOp, and captures
// the ALU result into a back-pressurable result register.
// Ports:
//   clk, rst    : clock, asynchronous active-high reset
//   flush       : synchronous clear of FIFO and result register
//   bus         : alu_issue_if.slave (packet in, result out)
//   alu_a/alu_b : FIFO head operands to the ALU (0 when empty)
//   alu_op      : decoded ALUOp for the FIFO head (000 when empty)
//   alu_q       : combinational ALU result
module alu_issue #(
    parameter int DEPTH = 4,
    parameter int TAGW  = 5
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    alu_issue_if.slave   bus,
    output logic [31:0]  alu_a,
    output logic [31:0]  alu_b,
    output logic [2:0]   alu_op,
    input  logic [31:0]  alu_q
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {
        CTL_MEM    = 2'b00,
        CTL_BRANCH = 2'b01,
        CTL_RTYPE  = 2'b10,
        CTL_RSVD   = 2'b11
    } ctl_e;

    typedef enum logic [2:0] {
        OP_AND = 3'b000,
        OP_OR  = 3'b001,
        OP_ADD = 3'b010,
        OP_SUB = 3'b011,
        OP_SLT = 3'b100,
        OP_ILL = 3'b111
    } op_e;

    logic [1:0]      mem_ctl   [DEPTH];
    logic [5:0]      mem_funct [DEPTH];
    logic [31:0]     mem_a     [DEPTH];
    logic [31:0]     mem_b     [DEPTH];
    logic [TAGW-1:0] mem_tag   [DEPTH];

    logic [AW-1:0]   wptr, rptr;
    logic [AW:0]     count;
    logic            empty, push, pop;
    op_e             head_op;
    logic            head_err;

    logic            res_valid_q;
    logic [31:0]     res_data_q;
    logic [TAGW-1:0] res_tag_q;
    logic            res_err_q;

    assign empty        = (count == '0);
    assign bus.in_ready = (count != FULL_CNT);
    // in_ready deliberately ignores a same-cycle pop: a full FIFO never accepts.
    assign push         = bus.in_valid & bus.in_ready;
    assign pop          = !empty & (!res_valid_q | bus.res_ready);

    always_comb begin
        head_op  = OP_ILL;
        head_err = 1'b1;
        case (mem_ctl[rptr])
            CTL_MEM:    begin head_op = OP_ADD; head_err = 1'b0; end
            CTL_BRANCH: begin head_op = OP_SUB; head_err = 1'b0; end
            CTL_RTYPE: begin
                case (mem_funct[rptr])
                    6'b100000: begin head_op = OP_ADD; head_err = 1'b0; end
                    6'b100010: begin head_op = OP_SUB; head_err = 1'b0; end
                    6'b100100: begin head_op = OP_AND; head_err = 1'b0; end
                    6'b100101: begin head_op = OP_OR;  head_err = 1'b0; end
                    6'b101010: begin head_op = OP_SLT; head_err = 1'b0; end
                    default:   begin head_op = OP_ILL; head_err = 1'b1; end
                endcase
            end
            default:    begin head_op = OP_ILL; head_err = 1'b1; end
        endcase
    end

    // Head operands are masked when empty so stale storage never reaches the ALU.
    assign alu_a  = empty ? '0 : mem_a[rptr];
    assign alu_b  = empty ? '0 : mem_b[rptr];
    assign alu_op = empty ? '0 : head_op;

    // Packet storage carries no reset; occupancy is tracked by count alone.
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem_ctl[wptr]   <= bus.in_aluop;
            mem_funct[wptr] <= bus.in_funct;
            mem_a[wptr]     <= bus.in_a;
            mem_b[wptr]     <= bus.in_b;
            mem_tag[wptr]   <= bus.in_tag;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr        <= '0;
            rptr        <= '0;
            count       <= '0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_tag_q   <= '0;
            res_err_q   <= 1'b0;
        end else if (flush) begin
            wptr        <= '0;
            rptr        <= '0;
            count       <= '0;
            res_valid_q <= 1'b0;
        end else begin
            if (push) begin
                wptr <= wptr + 1'b1;
            end
            if (pop) begin
                rptr        <= rptr + 1'b1;
                res_valid_q <= 1'b1;
                res_data_q  <= alu_q;
                res_tag_q   <= mem_tag[rptr];
                res_err_q   <= head_err;
            end else if (res_valid_q && bus.res_ready) begin
                res_valid_q <= 1'b0;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign bus.res_valid = res_valid_q;
    assign bus.res_data  = res_data_q;
    assign bus.res_tag   = res_tag_q;
    assign bus.res_err   = res_err_q;
endmodule
